// File: rtl/delay_line_sequencer.sv
// delay_line_sequencer
// Controls a short/long/bypass tap delay-line datapath. It picks the
// output path, clears both delay lines whenever the path is (re)entered,
// and holds out_valid low until the selected line has refilled. The
// sample data never passes through this block.
//
// Ports
//   clock       single clock, rising edge
//   reset       asynchronous active-high reset
//   ena         block enable; low returns to IDLE
//   req_valid   host path-change request valid
//   req_sel     requested path: 0 short, 1 long, 2 bypass, 3 illegal
//   req_ready   request accepted when req_valid && req_ready
//   line_clear  synchronous clear to both delay lines
//   path_sel    output-mux select (current path)
//   out_valid   mux output carries fully propagated samples
//   busy        high while refilling (FILL)
//   err_sticky  an illegal request was accepted; cleared only by reset
//   switch_cnt  completed path changes from RUN, saturating at 255
module delay_line_sequencer #(
    parameter int SHORT_LAT   = 60,
    parameter int LONG_LAT    = 90,
    parameter int DEFAULT_SEL = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ena,
    input  logic       req_valid,
    input  logic [1:0] req_sel,
    output logic       req_ready,
    output logic       line_clear,
    output logic [1:0] path_sel,
    output logic       out_valid,
    output logic       busy,
    output logic       err_sticky,
    output logic [7:0] switch_cnt
);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t     state;
    logic [7:0] fill_cnt;

    logic accept;
    logic illegal;
    logic change;

    // req_ready is itself registered and only high in IDLE/RUN, so an
    // accepted request can never arrive while filling.
    assign accept  = req_valid & req_ready;
    assign illegal = accept & (req_sel == 2'd3);
    assign change  = accept & ~illegal & (req_sel != path_sel);

    // Fill length per path; bypass needs only the clear cycle itself.
    function automatic logic [7:0] lat_of(input logic [1:0] sel);
        case (sel)
            2'd0:    lat_of = SHORT_LAT[7:0];
            2'd1:    lat_of = LONG_LAT[7:0];
            default: lat_of = 8'd0;
        endcase
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            path_sel   <= DEFAULT_SEL[1:0];
            line_clear <= 1'b1;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            req_ready  <= 1'b0;
            err_sticky <= 1'b0;
            switch_cnt <= 8'd0;
            fill_cnt   <= 8'd0;
        end else begin
            if (illegal)
                err_sticky <= 1'b1;

            case (state)
                IDLE: begin
                    // Path may be preset while parked; not counted as a switch.
                    if (change)
                        path_sel <= req_sel;
                    line_clear <= 1'b1;
                    out_valid  <= 1'b0;
                    if (ena) begin
                        state     <= FILL;
                        fill_cnt  <= lat_of(change ? req_sel : path_sel);
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                    end else begin
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end

                FILL: begin
                    if (!ena) begin
                        state      <= IDLE;
                        line_clear <= 1'b1;
                        out_valid  <= 1'b0;
                        busy       <= 1'b0;
                        req_ready  <= 1'b1;
                    end else begin
                        // Clear is a one-cycle pulse at fill entry.
                        line_clear <= 1'b0;
                        if (fill_cnt == 8'd0) begin
                            state     <= RUN;
                            busy      <= 1'b0;
                            out_valid <= 1'b1;
                            req_ready <= 1'b1;
                        end else begin
                            fill_cnt <= fill_cnt - 8'd1;
                        end
                    end
                end

                RUN: begin
                    // A path change is committed even if ena drops on the
                    // same cycle; IDLE then wins over starting a refill.
                    if (change) begin
                        path_sel <= req_sel;
                        if (switch_cnt != 8'hff)
                            switch_cnt <= switch_cnt + 8'd1;
                    end
                    if (!ena) begin
                        state      <= IDLE;
                        line_clear <= 1'b1;
                        out_valid  <= 1'b0;
                        busy       <= 1'b0;
                        req_ready  <= 1'b1;
                    end else if (change) begin
                        state      <= FILL;
                        fill_cnt   <= lat_of(req_sel);
                        line_clear <= 1'b1;
                        out_valid  <= 1'b0;
                        busy       <= 1'b1;
                        req_ready  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_line_sequencer.sv
// Bench for delay_line_sequencer: a constant vector table, directed
// multi-cycle sequences, then random traffic against a timestamp model.
module tb_delay_line_sequencer;

    localparam int SL = 60;
    localparam int LL = 90;

    typedef logic [14:0] obs_t; // {lc, path[1:0], ov, busy, rdy, err, sw[7:0]}

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ena = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_sel = 2'd0;
    logic       req_ready, line_clear, out_valid, busy, err_sticky;
    logic [1:0] path_sel;
    logic [7:0] switch_cnt;

    always #5 clock = ~clock;

    delay_line_sequencer #(.SHORT_LAT(SL), .LONG_LAT(LL), .DEFAULT_SEL(0)) dut (
        .clock(clock), .reset(reset), .ena(ena),
        .req_valid(req_valid), .req_sel(req_sel), .req_ready(req_ready),
        .line_clear(line_clear), .path_sel(path_sel), .out_valid(out_valid),
        .busy(busy), .err_sticky(err_sticky), .switch_cnt(switch_cnt)
    );

    int vectors = 0;
    int miscompares = 0;

    function automatic obs_t mk(input bit lc, input int p, input bit ov, input bit bz,
                                input bit rr, input bit er, input int sw);
        logic [1:0] p2;
        logic [7:0] s8;
        p2 = p[1:0];
        s8 = sw[7:0];
        return {lc, p2, ov, bz, rr, er, s8};
    endfunction

    function automatic obs_t dut_obs();
        return {line_clear, path_sel, out_valid, busy, req_ready, err_sticky, switch_cnt};
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h required %h (lc,path,ov,busy,rdy,err,sw)",
                     name, $time, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0d required %0d", name, $time, got, exp);
        end
    endtask

    // Reference model: remembers when the current fill began (m_c) and
    // derives every output from elapsed cycles versus the path latency.
    int cyc = 0, m_c = 0, m_path = 0, m_sw = 0;
    bit m_act = 1'b0, m_fresh = 1'b1, m_err = 1'b0;

    function automatic int lat(input int p);
        return (p == 0) ? SL : (p == 1) ? LL : 0;
    endfunction

    function automatic bit m_filling();
        return m_act && (cyc < m_c + 1 + lat(m_path));
    endfunction

    function automatic bit m_rr();
        return m_act ? !m_filling() : !m_fresh;
    endfunction

    function automatic obs_t model_obs();
        return mk(!m_act || (cyc == m_c), m_path, m_act && !m_filling(),
                  m_filling(), m_rr(), m_err, m_sw);
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_act <= 1'b0; m_fresh <= 1'b1; m_path <= 0; m_err <= 1'b0; m_sw <= 0;
        end else begin
            if (!m_act) begin
                if (req_valid && m_rr()) begin
                    if (req_sel == 2'd3) m_err <= 1'b1;
                    else m_path <= int'(req_sel);
                end
                m_fresh <= 1'b0;
                if (ena) begin
                    m_act <= 1'b1;
                    m_c <= cyc + 1;
                end
            end else begin
                if (req_valid && m_rr() && req_sel == 2'd3) m_err <= 1'b1;
                if (req_valid && m_rr() && req_sel != 2'd3 && int'(req_sel) != m_path) begin
                    m_path <= int'(req_sel);
                    m_sw <= (m_sw == 255) ? 255 : m_sw + 1;
                    m_c <= cyc + 1;
                end
                if (!ena) m_act <= 1'b0;
            end
            cyc <= cyc + 1;
        end
    end

    // Every elapsed cycle is also compared against the model.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            check("model", dut_obs(), model_obs());
        end
    endtask

    task automatic wait_valid(output int n, input int bound);
        n = 0;
        while (!out_valid && n < bound) begin
            step(1);
            n++;
        end
    endtask

    task automatic wait_ready(input int bound);
        int n;
        n = 0;
        while (!req_ready && n < bound) begin
            step(1);
            n++;
        end
        if (!req_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_ready: no req_ready within %0d cycles", bound);
        end
    endtask

    typedef struct {
        bit         ena;
        bit         rv;
        logic [1:0] sel;
        int         n;
        obs_t       exp;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int n;
        int bad;

        tbl[0]  = '{1'b0, 1'b0, 2'd0, 1,  mk(1, 0, 0, 0, 1, 0, 0)};
        tbl[1]  = '{1'b0, 1'b1, 2'd2, 1,  mk(1, 2, 0, 0, 1, 0, 0)};
        tbl[2]  = '{1'b1, 1'b0, 2'd0, 1,  mk(1, 2, 0, 1, 0, 0, 0)};
        tbl[3]  = '{1'b1, 1'b0, 2'd0, 1,  mk(0, 2, 1, 0, 1, 0, 0)};
        tbl[4]  = '{1'b1, 1'b1, 2'd2, 1,  mk(0, 2, 1, 0, 1, 0, 0)};
        tbl[5]  = '{1'b1, 1'b1, 2'd3, 1,  mk(0, 2, 1, 0, 1, 1, 0)};
        tbl[6]  = '{1'b1, 1'b1, 2'd0, 1,  mk(1, 0, 0, 1, 0, 1, 1)};
        tbl[7]  = '{1'b1, 1'b0, 2'd0, 1,  mk(0, 0, 0, 1, 0, 1, 1)};
        tbl[8]  = '{1'b1, 1'b0, 2'd0, 59, mk(0, 0, 0, 1, 0, 1, 1)};
        tbl[9]  = '{1'b1, 1'b0, 2'd0, 1,  mk(0, 0, 1, 0, 1, 1, 1)};
        tbl[10] = '{1'b0, 1'b0, 2'd0, 1,  mk(1, 0, 0, 0, 1, 1, 1)};
        tbl[11] = '{1'b0, 1'b1, 2'd3, 1,  mk(1, 0, 0, 0, 1, 1, 1)};

        // Asynchronous reset from power-up, observed before any clock edge.
        #1 reset = 1'b1;
        #1 check("reset_async", dut_obs(), mk(1, 0, 0, 0, 0, 0, 0));
        step(2);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            ena = tbl[i].ena;
            req_valid = tbl[i].rv;
            req_sel = tbl[i].sel;
            step(tbl[i].n);
            check($sformatf("table[%0d]", i), dut_obs(), tbl[i].exp);
        end
        req_valid = 1'b0;

        // Reset released with ena high: short fill from the default path.
        reset = 1'b1; ena = 1'b1;
        step(1);
        reset = 1'b0;
        step(1);
        check("dflt_C", dut_obs(), mk(1, 0, 0, 1, 0, 0, 0));
        wait_valid(n, 200);
        check_int("dflt_latency", n, 61);
        check("dflt_run", dut_obs(), mk(0, 0, 1, 0, 1, 0, 0));

        // Switch to long.
        req_valid = 1'b1; req_sel = 2'd1;
        step(1);
        req_valid = 1'b0;
        check("long_C", dut_obs(), mk(1, 1, 0, 1, 0, 0, 1));
        wait_valid(n, 200);
        check_int("long_latency", n, 91);

        // Bypass, then a repeated bypass request that must be a no-op.
        req_valid = 1'b1; req_sel = 2'd2;
        step(1);
        req_valid = 1'b0;
        check("byp_C", dut_obs(), mk(1, 2, 0, 1, 0, 0, 2));
        step(1);
        check("byp_run", dut_obs(), mk(0, 2, 1, 0, 1, 0, 2));
        req_valid = 1'b1;
        step(1);
        req_valid = 1'b0;
        check("byp_noop", dut_obs(), mk(0, 2, 1, 0, 1, 0, 2));

        // Request held through a long fill is taken on the first RUN cycle.
        req_valid = 1'b1; req_sel = 2'd1;
        step(1);
        req_sel = 2'd0;
        bad = 0; n = 0;
        while (!out_valid && n < 200) begin
            if (req_ready) bad++;
            step(1);
            n++;
        end
        check_int("held_ready_low", bad, 0);
        check_int("held_latency", n, 91);
        step(1);
        req_valid = 1'b0;
        check("held_accept", dut_obs(), mk(1, 0, 0, 1, 0, 0, 4));

        // Reset 30 cycles into a long fill, without an edge.
        wait_valid(n, 200);
        req_valid = 1'b1; req_sel = 2'd1;
        step(1);
        req_valid = 1'b0;
        step(30);
        reset = 1'b1;
        #1 check("rst_mid_fill", dut_obs(), mk(1, 0, 0, 0, 0, 0, 0));
        step(2);
        reset = 1'b0;

        // ena dropped mid-RUN, then restored.
        step(1);
        wait_valid(n, 200);
        ena = 1'b0;
        step(1);
        check("ena_low", dut_obs(), mk(1, 0, 0, 0, 1, 0, 0));
        ena = 1'b1;
        step(1);
        check("ena_refill", dut_obs(), mk(1, 0, 0, 1, 0, 0, 0));
        wait_valid(n, 200);
        check_int("ena_latency", n, 61);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(999) == 0);
            ena = ($urandom_range(99) >= 3);
            req_valid = ($urandom_range(99) < 6);
            req_sel = 2'($urandom_range(3));
            step(1);
        end
        reset = 1'b0; req_valid = 1'b0; ena = 1'b1;

        // switch_cnt saturation.
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        for (int i = 0; i < 260; i++) begin
            wait_ready(200);
            req_valid = 1'b1;
            req_sel = (i % 2 == 0) ? 2'd2 : 2'd0;
            step(1);
            req_valid = 1'b0;
        end
        check_int("sat_count", int'(switch_cnt), 255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/delay_line_sequencer.md
# delay_line_sequencer

Controller for the 8-bit tap delay-line datapath: owns the short/long/bypass path selection, clears the delay lines on every path change, and tracks pipeline refill so downstream logic only sees valid delayed samples. Sits between the host configuration interface (path requests) and the two delay lines plus output mux; it never touches the sample data itself.

## Interface
- SHORT_LAT, 60: clock cycles from short-line input to short-line output (1..255)
- LONG_LAT, 90: clock cycles from long-line input to long-line output (1..255)
- DEFAULT_SEL, 0: path selected after reset (0 short, 1 long, 2 bypass)

- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- ena  in  1  design enable; low parks the block in IDLE
- req_valid  in  1  host path-change request valid
- req_sel  in  2  requested path: 0 short, 1 long, 2 bypass, 3 illegal
- req_ready  out  1  request accepted on cycle where req_valid && req_ready
- line_clear  out  1  synchronous clear to both delay lines
- path_sel  out  2  output-mux select, equals current path
- out_valid  out  1  mux output holds samples fully propagated through current path
- busy  out  1  high in FILL
- err_sticky  out  1  set on accepted illegal request; cleared only by reset
- switch_cnt  out  8  completed path changes, saturates at 255

## Operation
- States: IDLE, FILL, RUN. All outputs registered.
- Reset values: state IDLE, path_sel=DEFAULT_SEL, line_clear=1, out_valid=0, busy=0, req_ready=0, err_sticky=0, switch_cnt=0, fill counter 0.
- IDLE: line_clear=1, out_valid=0, req_ready=1. Legal request updates path_sel, no other effect. ena high → FILL (cycle after ena sampled high).
- FILL: line_clear high on first FILL cycle only, then 0; busy=1; req_ready=0; fill counter loaded with LAT of path_sel (0 for bypass) on entry, decrements each cycle; at expiry → RUN.
- RUN: out_valid=1, req_ready=1, line_clear=0.
  - Legal req_sel different from path_sel: path_sel updates next cycle, out_valid drops same edge, → FILL, switch_cnt +1 (saturating).
  - Legal req_sel equal to path_sel: accepted, no-op, no flush, switch_cnt unchanged.
  - req_sel=3 in any state with req_ready=1: accepted, err_sticky set, path/state unchanged.
- ena low in FILL or RUN: next cycle → IDLE (out_valid=0, line_clear=1); request on that same cycle is not accepted in FILL, and in RUN is accepted (path_sel updated, switch_cnt +1) but IDLE takes priority over FILL.
- Counter width 8 bits; LAT values outside 1..255 are a configuration error, not checked in RTL.

## Timing
- Define C = first FILL cycle (line_clear=1). First out_valid=1 cycle = C+1+LAT (short/long), C+1 for bypass.
- Request accepted at edge k (RUN): path_sel, out_valid=0, state FILL visible at k+1; that is cycle C.
- ena rising sampled at edge k in IDLE: C = k+1.
- Reset deassertion with ena high: first FILL cycle is the cycle after first edge with reset low; out_valid after DEFAULT_SEL latency.
- Reset asserted mid-FILL/RUN: all outputs to reset values asynchronously, without waiting for an edge; in-flight fill discarded; switch_cnt cleared.
- Back-to-back requests: at most one accepted per FILL; a held req_valid during FILL is accepted on first RUN cycle.

## Test plan
- Reset, ena=1, defaults: line_clear pulse at C, out_valid rises exactly at C+61, path_sel=0, switch_cnt=0.
- In RUN request req_sel=1: req_ready=1 accepted, out_valid low next cycle, path_sel=1, out_valid high 91 cycles after line_clear pulse, switch_cnt=1.
- Request req_sel=2 from RUN then req_sel=2 again: bypass valid at C+1; second request no-op, switch_cnt increments only once.
- req_sel=3 in RUN: err_sticky=1, path_sel and out_valid unchanged; persists until reset.
- req_valid held high during FILL with req_sel=0: req_ready=0 throughout fill, accepted on first RUN cycle, new FILL starts next cycle.
- Assert reset at cycle 30 of a long fill, and separately drop ena mid-RUN: reset clears all outputs without a clock edge; ena low gives IDLE with line_clear=1, out_valid=0 next cycle, refill on ena return.
